// File: rtl/pencoder_pkg.sv
// rtl/pencoder_pkg.sv - shared types and constants for the priority scan encoder
package pencoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int PRIO_MSB_FIRST = 1;
    localparam int PRIO_LSB_FIRST = 0;

endpackage

// File: rtl/pencoder_prio_enc.sv
// rtl/pencoder_prio_enc.sv - combinational parametrised priority encoder
module prio_enc
    import pencoder_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = PRIO_MSB_FIRST,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // The loop direction makes the winning bit the last one visited.
    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST != PRIO_LSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pencoder_scan.sv
// rtl/pencoder_scan.sv - emits the index of every set request bit, one per beat, in priority order
module pencoder_scan
    import pencoder_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MSB_FIRST = PRIO_MSB_FIRST,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             none_q, none_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             single;
    logic             beat;
    logic             accept;
    logic [WIDTH-1:0] clr_mask;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign single   = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    assign clr_mask = WIDTH'(1) << enc_idx;

    assign out_valid = (state_q == SCAN);
    assign out_idx   = none_q ? '0 : enc_idx;
    assign out_last  = out_valid && (single || none_q);
    assign out_none  = out_valid && none_q;

    assign beat     = out_valid && out_ready;
    assign in_ready = (state_q == IDLE) || (beat && out_last);
    assign accept   = in_valid && in_ready;

    // An accept on the final beat overrides the return to IDLE, giving no bubble.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        none_d    = none_q;
        if (beat) begin
            pending_d = pending_q & ~clr_mask;
            if (out_last) begin
                state_d = IDLE;
                none_d  = 1'b0;
            end
        end
        if (accept) begin
            pending_d = in_vec;
            none_d    = (in_vec == '0);
            state_d   = SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            none_q    <= none_d;
        end
    end

endmodule

// File: tb/tb_pencoder_scan.sv
// tb/tb_pencoder_scan.sv - directed vector bench for pencoder_scan
module tb_pencoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, MSB first
    logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, out_none;
    logic [7:0] in_vec;
    logic [2:0] out_idx;

    // 8-bit, LSB first
    logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last, l_out_none;
    logic [7:0] l_in_vec;
    logic [2:0] l_out_idx;

    // 4-bit, MSB first
    logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_last, n_out_none;
    logic [3:0] n_in_vec;
    logic [1:0] n_out_idx;

    pencoder_scan #(.WIDTH(8), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_none(out_none)
    );

    pencoder_scan #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_vec(l_in_vec),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .out_none(l_out_none)
    );

    pencoder_scan #(.WIDTH(4), .MSB_FIRST(1)) u_dut_w4 (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_vec(n_in_vec),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_idx(n_out_idx),
        .out_last(n_out_last), .out_none(n_out_none)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] vec;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [2:0] idx;
        logic       last;
        logic       none;
    } row_t;

    row_t rows[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_vec = '0; l_out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_vec = '0; n_out_ready = 1'b1;

        // rst iv vec ordy | in_ready out_valid idx last none   (outputs seen before the closing edge)
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});  // reset state
        rows.push_back('{0, 1, 8'hA4, 1,  1, 0, 3'd0, 0, 0});  // accept 1010_0100
        rows.push_back('{0, 0, 8'hA4, 1,  0, 1, 3'd7, 0, 0});
        rows.push_back('{0, 0, 8'hA4, 1,  0, 1, 3'd5, 0, 0});
        rows.push_back('{0, 0, 8'hA4, 1,  1, 1, 3'd2, 1, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});
        rows.push_back('{0, 1, 8'hA4, 1,  1, 0, 3'd0, 0, 0});  // backpressure run
        rows.push_back('{0, 1, 8'hFF, 0,  0, 1, 3'd7, 0, 0});  // in_vec ignored while stalled
        rows.push_back('{0, 1, 8'hFF, 0,  0, 1, 3'd7, 0, 0});
        rows.push_back('{0, 0, 8'hFF, 0,  0, 1, 3'd7, 0, 0});
        rows.push_back('{0, 0, 8'h00, 1,  0, 1, 3'd7, 0, 0});
        rows.push_back('{0, 0, 8'h00, 1,  0, 1, 3'd5, 0, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 1, 3'd2, 1, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});
        rows.push_back('{0, 1, 8'h00, 1,  1, 0, 3'd0, 0, 0});  // all-zero vector
        rows.push_back('{0, 0, 8'h00, 1,  1, 1, 3'd0, 1, 1});
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});
        rows.push_back('{0, 1, 8'h81, 1,  1, 0, 3'd0, 0, 0});  // back-to-back
        rows.push_back('{0, 0, 8'h81, 1,  0, 1, 3'd7, 0, 0});
        rows.push_back('{0, 1, 8'h02, 1,  1, 1, 3'd0, 1, 0});
        rows.push_back('{0, 0, 8'h02, 1,  1, 1, 3'd1, 1, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});
        rows.push_back('{0, 1, 8'hFF, 1,  1, 0, 3'd0, 0, 0});  // reset mid-scan
        rows.push_back('{0, 0, 8'hFF, 1,  0, 1, 3'd7, 0, 0});
        rows.push_back('{1, 0, 8'hFF, 1,  0, 1, 3'd6, 0, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});
        rows.push_back('{0, 1, 8'h10, 1,  1, 0, 3'd0, 0, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 1, 3'd4, 1, 0});
        rows.push_back('{0, 0, 8'h00, 1,  1, 0, 3'd0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        foreach (rows[i]) begin
            rst       = rows[i].rst;
            in_valid  = rows[i].iv;
            in_vec    = rows[i].vec;
            out_ready = rows[i].ordy;
            @(negedge clk);
            check("in_ready",  i, 32'(in_ready),  32'(rows[i].ir));
            check("out_valid", i, 32'(out_valid), 32'(rows[i].ov));
            check("out_idx",   i, 32'(out_idx),   32'(rows[i].idx));
            check("out_last",  i, 32'(out_last),  32'(rows[i].last));
            check("out_none",  i, 32'(out_none),  32'(rows[i].none));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // LSB-first: 1010_0100 -> 2, 5, 7
        begin
            int exp_l[3] = '{2, 5, 7};
            l_in_valid = 1'b1; l_in_vec = 8'hA4;
            @(negedge clk);
            check("lsb_accept_ready", 100, 32'(l_in_ready), 32'd1);
            @(posedge clk); #1;
            l_in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("lsb_valid", 100 + k, 32'(l_out_valid), 32'd1);
                check("lsb_idx",   100 + k, 32'(l_out_idx),   32'(exp_l[k]));
                check("lsb_last",  100 + k, 32'(l_out_last),  32'(k == 2));
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("lsb_idle", 103, 32'(l_out_valid), 32'd0);
        end

        // 4-bit MSB-first: 0110 -> 2, 1
        begin
            int exp_n[2] = '{2, 1};
            n_in_valid = 1'b1; n_in_vec = 4'b0110;
            @(posedge clk); #1;
            n_in_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check("w4_valid", 200 + k, 32'(n_out_valid), 32'd1);
                check("w4_idx",   200 + k, 32'(n_out_idx),   32'(exp_n[k]));
                check("w4_last",  200 + k, 32'(n_out_last),  32'(k == 1));
                check("w4_none",  200 + k, 32'(n_out_none),  32'd0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            check("w4_idle", 202, 32'(n_out_valid), 32'd0);
            check("w4_ready", 202, 32'(n_in_ready), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pencoder_scan.md
Name: pencoder_scan

Overview:
- Parametrised, sequential successor to the 4-to-2 priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake, then emits the index of every set bit, one index per cycle, in priority order. Each index is sent on a valid/ready output stream, and the last index of the vector is flagged.
- Sits between request-collection logic (interrupt or event bitmaps) and a serial consumer that services one request per beat.

Parameters:
- WIDTH, 8, request vector width; legal range 2 to 64.
- MSB_FIRST, 1, priority order: 1 = highest index first, 0 = lowest index first.
- IDX_W, $clog2(WIDTH), index width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  request bitmap.
- out_valid  output  1  out_idx, out_last and out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDX_W  index of the current highest-priority pending bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  accepted vector was all-zero; this beat carries no index.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- State machine, two states:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: out_valid=1, pending register non-empty, or the none flag is set.
- Accept condition: in_valid && in_ready. On accept:
  - pending <= in_vec; none_r <= (in_vec==0); state <= SCAN.
  - First out_valid appears the next cycle, so latency is 1 cycle.
- Beats in SCAN:
  - out_idx = priority index of pending, from the combinational prio_enc on the registered pending value.
  - out_last = (pending has exactly one bit set) || none_r.
  - out_none = none_r; out_idx = 0 when none_r is set.
- Beat transfer: out_valid && out_ready.
  - Clear bit out_idx in pending.
  - If out_last, clear none_r and leave SCAN.
- Throughput: one index per cycle while out_ready=1.
- Back-to-back vectors:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - A vector accepted in the same cycle as the final beat transfer reloads pending, and SCAN continues with no bubble.
- Backpressure:
  - While out_valid && !out_ready, out_idx, out_last and out_none hold stable; pending does not change.
  - in_ready=0 unless the final beat transfers.
- in_vec is sampled only on accept; changes to in_vec at other times have no effect.
- Reset values, applied at the first clk edge with rst=1, including mid-SCAN:
  - state=IDLE, pending=0, none_r=0.
  - out_valid=0, in_ready=1, out_idx=0, out_last=0, out_none=0.
  - Any partially scanned vector is discarded.
- Width rules:
  - For WIDTH that is not a power of two, out_idx never exceeds WIDTH-1.
  - Unused encodings never appear.
- Ties are impossible: each bit has a unique priority fixed by MSB_FIRST.

Decomposition:
- Shared package pencoder_pkg holds:
  - state typedef: IDLE=1'b0, SCAN=1'b1.
  - constants PRIO_MSB_FIRST=1 and PRIO_LSB_FIRST=0.
- One sub-module, prio_enc, is natural:
  - Combinational parametrised priority encoder with parameters WIDTH and MSB_FIRST.
  - Ports: vec in, idx out, any out.
  - Instantiated once on pending.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1, in_vec=8'b1010_0100 -> out_idx 7, 5, 2 on three consecutive cycles starting 1 cycle after accept; out_last=1 only with idx 2; in_ready=1 in the idx-2 cycle.
- Same vector with out_ready held low 3 cycles on the first beat -> out_idx=7, out_last=0 stable for 4 cycles; in_ready=0 throughout; then 5, 2.
- in_vec=8'h00 -> single beat with out_none=1, out_last=1, out_idx=0; returns to IDLE.
- Back-to-back: 8'h81 then 8'h02, presented on the final-beat cycle -> 7, 0, 1 with no idle cycle between; out_last on 0 and 1.
- MSB_FIRST=0, in_vec=8'b1010_0100 -> 2, 5, 7. WIDTH=4, MSB_FIRST=1, in_vec=4'b0110 -> 2, 1.
- rst asserted after first beat of 8'hFF -> next cycle out_valid=0, in_ready=1; new vector 8'h10 yields only idx 4.
